// File: rtl/sp_if_ddr_arb_pkg.sv
// Shared types and constants for the DDR command-channel arbiter.
// Command layout matches the DDR access block's wxr/area/addr/size fields.
package sp_if_ddr_arb_pkg;

   localparam int unsigned TIMEOUT_CYC_DEF = 1048576;
   localparam int unsigned GID_W           = 3;

   typedef struct packed {
      logic        wxr;
      logic [3:0]  area;
      logic [26:0] addr;
      logic [31:0] size;
   } ddr_cmd_t;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      BUSY
   } arb_state_t;

endpackage

// File: rtl/sp_if_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, with wrap.
// Kept generic so the stream arbiters can reuse it.
module sp_if_rr_pick #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic [IDX_W-1:0]   gnt_idx,
   output logic               gnt_any
);

   always_comb begin
      int unsigned j;
      j       = 0;
      gnt_idx = '0;
      gnt_any = 1'b0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         j = {{(32-IDX_W){1'b0}}, ptr} + k;
         if (j >= NUM_REQ) j = j - NUM_REQ;
         if (!gnt_any && req[IDX_W'(j)]) begin
            gnt_any = 1'b1;
            gnt_idx = IDX_W'(j);
         end
      end
   end

endmodule

// File: rtl/sp_if_ddr_arb.sv
// Round-robin arbiter sharing one DDR access command channel among NUM_REQ
// interface controllers; one queued request per requester, registered outputs.
module sp_if_ddr_arb
   import sp_if_ddr_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ     = 4,
   parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF,
   parameter int unsigned TO_W        = 21
) (
   input  logic                  i_clk156m,
   input  logic                  i_arst_n,
   input  logic [NUM_REQ-1:0]    i_req_start,
   input  logic [NUM_REQ-1:0]    i_req_wxr,
   input  logic [NUM_REQ*4-1:0]  i_req_area,
   input  logic [NUM_REQ*27-1:0] i_req_addr,
   input  logic [NUM_REQ*32-1:0] i_req_size,
   output logic [NUM_REQ-1:0]    o_req_endp,
   output logic [NUM_REQ-1:0]    o_req_ovf,
   output logic                  o_ddr_wxr,
   output logic [3:0]            o_ddr_area,
   output logic [26:0]           o_ddr_addr,
   output logic [31:0]           o_ddr_size,
   output logic                  o_ddr_start,
   input  logic                  i_ddr_endp,
   output logic [GID_W-1:0]      o_grant_id,
   output logic                  o_grant_vld,
   output logic                  o_timeout,
   output logic                  o_busy
);

   localparam int unsigned IDX_W = $clog2(NUM_REQ);

   arb_state_t          state, state_nxt;
   logic [NUM_REQ-1:0]  pend, clr, endp_q, endp_nxt, ovf_q;
   ddr_cmd_t            cmd [NUM_REQ];
   ddr_cmd_t            ddr_q, ddr_nxt;
   logic [IDX_W-1:0]    ptr, ptr_nxt, gid, gid_nxt, pick_idx;
   logic                pick_any, take;
   logic                start_q, start_nxt, vld_q, vld_nxt, to_q, to_nxt;
   logic [TO_W-1:0]     cnt, cnt_nxt;

   sp_if_rr_pick #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_pick (
      .req     (pend),
      .ptr     (ptr),
      .gnt_idx (pick_idx),
      .gnt_any (pick_any)
   );

   assign clr = take ? (NUM_REQ'(1) << pick_idx) : '0;

   // A start landing on the cycle its pending entry is granted is accepted as a fresh request.
   always_ff @(posedge i_clk156m or negedge i_arst_n) begin
      if (!i_arst_n) begin
         pend  <= '0;
         ovf_q <= '0;
         for (int unsigned i = 0; i < NUM_REQ; i++) cmd[i] <= '0;
      end else begin
         for (int unsigned i = 0; i < NUM_REQ; i++) begin
            ovf_q[i] <= 1'b0;
            if (i_req_start[i] && (!pend[i] || clr[i])) begin
               pend[i] <= 1'b1;
               cmd[i]  <= {i_req_wxr[i], i_req_area[i*4 +: 4],
                           i_req_addr[i*27 +: 27], i_req_size[i*32 +: 32]};
            end else if (i_req_start[i]) begin
               ovf_q[i] <= 1'b1;
            end else if (clr[i]) begin
               pend[i] <= 1'b0;
            end
         end
      end
   end

   always_comb begin
      state_nxt = state;
      ddr_nxt   = ddr_q;
      gid_nxt   = gid;
      ptr_nxt   = ptr;
      cnt_nxt   = cnt;
      start_nxt = 1'b0;
      vld_nxt   = vld_q;
      endp_nxt  = '0;
      to_nxt    = 1'b0;
      take      = 1'b0;
      case (state)
         IDLE: begin
            vld_nxt = 1'b0;
            // Wait out the completion-pulse cycle so o_grant_vld drops between grants.
            if (pick_any && (endp_q == '0)) begin
               take      = 1'b1;
               ddr_nxt   = cmd[pick_idx];
               gid_nxt   = pick_idx;
               ptr_nxt   = (pick_idx == IDX_W'(NUM_REQ-1)) ? '0 : pick_idx + 1'b1;
               start_nxt = 1'b1;
               vld_nxt   = 1'b1;
               state_nxt = ISSUE;
            end
         end
         ISSUE: begin
            cnt_nxt   = '0;
            state_nxt = BUSY;
         end
         BUSY: begin
            if (i_ddr_endp) begin
               endp_nxt  = NUM_REQ'(1) << gid;
               state_nxt = IDLE;
            end else if (cnt == TO_W'(TIMEOUT_CYC-1)) begin
               endp_nxt  = NUM_REQ'(1) << gid;
               to_nxt    = 1'b1;
               state_nxt = IDLE;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge i_clk156m or negedge i_arst_n) begin
      if (!i_arst_n) begin
         state   <= IDLE;
         ddr_q   <= '0;
         gid     <= '0;
         ptr     <= '0;
         cnt     <= '0;
         start_q <= 1'b0;
         vld_q   <= 1'b0;
         endp_q  <= '0;
         to_q    <= 1'b0;
      end else begin
         state   <= state_nxt;
         ddr_q   <= ddr_nxt;
         gid     <= gid_nxt;
         ptr     <= ptr_nxt;
         cnt     <= cnt_nxt;
         start_q <= start_nxt;
         vld_q   <= vld_nxt;
         endp_q  <= endp_nxt;
         to_q    <= to_nxt;
      end
   end

   assign o_ddr_wxr   = ddr_q.wxr;
   assign o_ddr_area  = ddr_q.area;
   assign o_ddr_addr  = ddr_q.addr;
   assign o_ddr_size  = ddr_q.size;
   assign o_ddr_start = start_q;
   assign o_grant_id  = GID_W'(gid);
   assign o_grant_vld = vld_q;
   assign o_req_endp  = endp_q;
   assign o_req_ovf   = ovf_q;
   assign o_timeout   = to_q;
   assign o_busy      = (state != IDLE);

endmodule

// File: tb/tb_sp_if_ddr_arb.sv
// Self-checking bench for sp_if_ddr_arb: scenario tasks against a queue/round-robin
// reference model; timing expectations derived from the request/completion latencies.
module tb_sp_if_ddr_arb;
   import sp_if_ddr_arb_pkg::*;

   localparam int N  = 4;
   localparam int TO = 16;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [N-1:0]    req_start = '0, req_wxr = '0;
   logic [N*4-1:0]  req_area = '0;
   logic [N*27-1:0] req_addr = '0;
   logic [N*32-1:0] req_size = '0;
   logic            ddr_endp = 1'b0;
   logic [N-1:0]    req_endp, req_ovf;
   logic            ddr_wxr, ddr_start, grant_vld, timeout, busy;
   logic [3:0]      ddr_area;
   logic [26:0]     ddr_addr;
   logic [31:0]     ddr_size;
   logic [2:0]      grant_id;

   int n_checks = 0;
   int n_fail   = 0;

   ddr_cmd_t m_cmd [N];
   bit       m_pend [N];
   int       m_ptr;

   always #3 clk = ~clk;

   sp_if_ddr_arb #(.NUM_REQ(N), .TIMEOUT_CYC(TO), .TO_W(5)) dut (
      .i_clk156m(clk), .i_arst_n(rst_n),
      .i_req_start(req_start), .i_req_wxr(req_wxr), .i_req_area(req_area),
      .i_req_addr(req_addr), .i_req_size(req_size),
      .o_req_endp(req_endp), .o_req_ovf(req_ovf),
      .o_ddr_wxr(ddr_wxr), .o_ddr_area(ddr_area), .o_ddr_addr(ddr_addr), .o_ddr_size(ddr_size),
      .o_ddr_start(ddr_start), .i_ddr_endp(ddr_endp),
      .o_grant_id(grant_id), .o_grant_vld(grant_vld), .o_timeout(timeout), .o_busy(busy)
   );

   // ---------------- reference model ----------------
   function automatic void m_reset();
      for (int i = 0; i < N; i++) m_pend[i] = 1'b0;
      m_ptr = 0;
   endfunction

   function automatic bit m_request(int i, ddr_cmd_t c);
      if (m_pend[i]) return 1'b1;
      m_pend[i] = 1'b1;
      m_cmd[i]  = c;
      return 1'b0;
   endfunction

   function automatic int m_pick();
      for (int k = 0; k < N; k++) begin
         int j;
         j = (m_ptr + k) % N;
         if (m_pend[j]) return j;
      end
      return -1;
   endfunction

   function automatic void m_grant(int g);
      m_pend[g] = 1'b0;
      m_ptr     = (g + 1) % N;
   endfunction

   function automatic logic [N-1:0] onehot(int g);
      return N'(1) << g;
   endfunction

   function automatic ddr_cmd_t rand_cmd();
      return {$urandom(), $urandom()};
   endfunction

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_cmd(int i, ddr_cmd_t c);
      req_wxr[i]          = c.wxr;
      req_area[i*4 +: 4]  = c.area;
      req_addr[i*27 +: 27] = c.addr;
      req_size[i*32 +: 32] = c.size;
   endtask

   task automatic pulse(logic [N-1:0] m);
      req_start = m;
      tick();
      req_start = '0;
   endtask

   task automatic drive_endp(int d);
      repeat (d) tick();
      ddr_endp = 1'b1;
      tick();
      ddr_endp = 1'b0;
   endtask

   task automatic wait_start(int budget, output int n, output bit ok);
      n  = 0;
      ok = 1'b0;
      while (n < budget && !ok) begin
         if (ddr_start === 1'b1) ok = 1'b1;
         else begin
            tick();
            n++;
         end
      end
   endtask

   task automatic apply_reset();
      rst_n     = 1'b0;
      req_start = '0;
      ddr_endp  = 1'b0;
      repeat (2) tick();
      rst_n = 1'b1;
      m_reset();
      tick();
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      repeat (3) tick();
      n_checks++;
      if ({req_endp, req_ovf, ddr_start, grant_vld, timeout, busy, grant_id} !== '0) begin
         n_fail++;
         $display("FAIL reset_ctrl: got %b want 0",
                  {req_endp, req_ovf, ddr_start, grant_vld, timeout, busy, grant_id});
      end
      n_checks++;
      if ({ddr_wxr, ddr_area, ddr_addr, ddr_size} !== '0) begin
         n_fail++;
         $display("FAIL reset_cmd: got %h want 0", {ddr_wxr, ddr_area, ddr_addr, ddr_size});
      end
      rst_n = 1'b1;
      m_reset();
      tick();
   endtask

   task automatic test_single();
      ddr_cmd_t c;
      int g;
      apply_reset();
      c.wxr = 1'b0; c.area = 4'h3; c.addr = 27'h0123456; c.size = 32'h4000;
      set_cmd(0, c);
      void'(m_request(0, c));
      pulse(4'b0001);                              // now t+1
      n_checks++;
      if (ddr_start !== 1'b0) begin n_fail++; $display("FAIL single_early: start=%b want 0 at t+1", ddr_start); end
      tick();                                      // t+2
      g = m_pick();
      n_checks++;
      if (ddr_start !== 1'b1 || grant_id !== 3'(g) || grant_vld !== 1'b1) begin
         n_fail++;
         $display("FAIL single_start: start=%b id=%0d vld=%b want 1/%0d/1", ddr_start, grant_id, grant_vld, g);
      end
      n_checks++;
      if ({ddr_wxr, ddr_area, ddr_addr, ddr_size} !== m_cmd[g]) begin
         n_fail++;
         $display("FAIL single_fields: got %h want %h", {ddr_wxr, ddr_area, ddr_addr, ddr_size}, m_cmd[g]);
      end
      m_grant(g);
      tick();                                      // t+3
      n_checks++;
      if (ddr_start !== 1'b0 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL single_busy: start=%b busy=%b want 0/1", ddr_start, busy);
      end
      drive_endp(7);                               // endp at t+10, now t+11
      n_checks++;
      if (req_endp !== 4'b0001 || grant_vld !== 1'b1) begin
         n_fail++;
         $display("FAIL single_endp: endp=%b vld=%b want 0001/1", req_endp, grant_vld);
      end
      tick();                                      // t+12
      n_checks++;
      if (req_endp !== 4'b0000 || busy !== 1'b0 || grant_vld !== 1'b0) begin
         n_fail++;
         $display("FAIL single_idle: endp=%b busy=%b vld=%b want 0000/0/0", req_endp, busy, grant_vld);
      end
      n_checks++;
      if ({ddr_wxr, ddr_area, ddr_addr, ddr_size} !== c) begin
         n_fail++;
         $display("FAIL single_hold: got %h want %h", {ddr_wxr, ddr_area, ddr_addr, ddr_size}, c);
      end
   endtask

   task automatic test_fairness();
      int n, g;
      bit ok;
      apply_reset();
      for (int i = 0; i < N; i++) begin
         ddr_cmd_t c;
         c = rand_cmd();
         set_cmd(i, c);
         void'(m_request(i, c));
      end
      pulse(4'b1111);
      for (int k = 0; k < N; k++) begin
         wait_start(8, n, ok);
         n_checks++;
         if (!ok || n != ((k == 0) ? 1 : 2)) begin
            n_fail++;
            $display("FAIL fair_latency[%0d]: seen=%0b after %0d cycles want %0d", k, ok, n, (k == 0) ? 1 : 2);
         end
         g = m_pick();
         n_checks++;
         if (grant_id !== 3'(k) || grant_id !== 3'(g) ||
             {ddr_wxr, ddr_area, ddr_addr, ddr_size} !== m_cmd[g]) begin
            n_fail++;
            $display("FAIL fair_grant[%0d]: id=%0d cmd=%h want id=%0d cmd=%h", k, grant_id,
                     {ddr_wxr, ddr_area, ddr_addr, ddr_size}, g, m_cmd[g]);
         end
         m_grant(g);
         drive_endp(5);
         n_checks++;
         if (req_endp !== onehot(g)) begin
            n_fail++;
            $display("FAIL fair_endp[%0d]: got %b want %b", k, req_endp, onehot(g));
         end
      end
      for (int i = 0; i < N; i += 3) begin
         ddr_cmd_t c;
         c = rand_cmd();
         set_cmd(i, c);
         void'(m_request(i, c));
      end
      pulse(4'b1001);
      for (int k = 0; k < 2; k++) begin
         wait_start(8, n, ok);
         g = m_pick();
         n_checks++;
         if (!ok || grant_id !== 3'(g) || {ddr_wxr, ddr_area, ddr_addr, ddr_size} !== m_cmd[g]) begin
            n_fail++;
            $display("FAIL fair_wrap[%0d]: seen=%0b id=%0d want %0d", k, ok, grant_id, g);
         end
         m_grant(g);
         drive_endp(3);
      end
   endtask

   task automatic test_overflow();
      ddr_cmd_t c, c2;
      int n, g, cnt_endp;
      bit ok, extra;
      apply_reset();
      c = rand_cmd();
      set_cmd(0, c);
      void'(m_request(0, c));
      pulse(4'b0001);
      wait_start(4, n, ok);
      m_grant(m_pick());
      tick();                                      // s+1
      c = rand_cmd();
      set_cmd(2, c);
      n_checks++;
      if (m_request(2, c) !== 1'b0) begin n_fail++; $display("FAIL ovf_model: first request refused"); end
      pulse(4'b0100);
      n_checks++;
      if (req_ovf !== 4'b0000) begin n_fail++; $display("FAIL ovf_first: got %b want 0000", req_ovf); end
      tick();
      tick();                                      // s+4
      c2 = rand_cmd();
      set_cmd(2, c2);
      pulse(4'b0100);
      n_checks++;
      if (req_ovf !== (m_request(2, c2) ? 4'b0100 : 4'b0000)) begin
         n_fail++;
         $display("FAIL ovf_second: got %b want 0100", req_ovf);
      end
      tick();
      n_checks++;
      if (req_ovf !== 4'b0000) begin n_fail++; $display("FAIL ovf_pulse: got %b want 0000", req_ovf); end
      drive_endp(2);
      wait_start(8, n, ok);
      g = m_pick();
      n_checks++;
      if (!ok || n != 2 || grant_id !== 3'(g) || ddr_addr !== m_cmd[g].addr) begin
         n_fail++;
         $display("FAIL ovf_issue: seen=%0b n=%0d id=%0d addr=%h want n=2 id=%0d addr=%h",
                  ok, n, grant_id, ddr_addr, g, m_cmd[g].addr);
      end
      m_grant(g);
      drive_endp($urandom_range(8, 1));
      cnt_endp = int'(req_endp[2]);
      extra    = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         cnt_endp += int'(req_endp[2]);
         extra |= ddr_start;
      end
      n_checks++;
      if (cnt_endp != 1 || extra !== 1'b0) begin
         n_fail++;
         $display("FAIL ovf_once: endp2 pulses=%0d extra_start=%b want 1/0", cnt_endp, extra);
      end
   endtask

   task automatic test_self_rerequest();
      ddr_cmd_t c;
      int n, g;
      bit ok;
      apply_reset();
      c = rand_cmd();
      set_cmd(1, c);
      void'(m_request(1, c));
      pulse(4'b0010);
      wait_start(4, n, ok);
      m_grant(m_pick());
      tick();
      c = rand_cmd();
      set_cmd(1, c);
      void'(m_request(1, c));
      pulse(4'b0010);
      drive_endp(3);
      n_checks++;
      if (req_endp !== 4'b0010) begin n_fail++; $display("FAIL self_endp: got %b want 0010", req_endp); end
      wait_start(8, n, ok);
      g = m_pick();
      n_checks++;
      if (!ok || n != 2 || grant_id !== 3'(g) || {ddr_wxr, ddr_area, ddr_addr, ddr_size} !== m_cmd[g]) begin
         n_fail++;
         $display("FAIL self_regrant: seen=%0b n=%0d id=%0d want n=2 id=%0d", ok, n, grant_id, g);
      end
      m_grant(g);
      drive_endp(2);
   endtask

   task automatic test_timeout();
      int n, k, cyc;
      bit ok, seen;
      apply_reset();
      k = $urandom_range(N-1, 0);
      set_cmd(k, rand_cmd());
      void'(m_request(k, m_cmd[k]));
      pulse(onehot(k));
      wait_start(4, n, ok);
      m_grant(k);
      cyc  = 0;
      seen = 1'b0;
      while (cyc < 30 && !seen) begin
         tick();
         cyc++;
         if (timeout === 1'b1) seen = 1'b1;
      end
      n_checks++;
      if (!seen || cyc != TO + 1) begin
         n_fail++;
         $display("FAIL to_cycle: seen=%0b at %0d cycles after start want %0d", seen, cyc, TO + 1);
      end
      n_checks++;
      if (req_endp !== onehot(k)) begin
         n_fail++;
         $display("FAIL to_endp: got %b want %b", req_endp, onehot(k));
      end
      tick();
      n_checks++;
      if (timeout !== 1'b0 || req_endp !== '0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL to_after: to=%b endp=%b busy=%b want 0/0/0", timeout, req_endp, busy);
      end
      ddr_endp = 1'b1;
      tick();
      ddr_endp = 1'b0;
      tick();
      n_checks++;
      if (req_endp !== '0 || timeout !== 1'b0 || ddr_start !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL to_stray: endp=%b to=%b start=%b busy=%b want all 0", req_endp, timeout, ddr_start, busy);
      end
   endtask

   task automatic test_reset_mid();
      int n;
      bit ok, acc_start;
      logic [N-1:0] acc_endp;
      apply_reset();
      set_cmd(0, rand_cmd());
      pulse(4'b0001);
      wait_start(4, n, ok);
      tick();
      tick();
      set_cmd(1, rand_cmd());
      pulse(4'b0010);
      tick();
      #1 rst_n = 1'b0;
      #1;
      n_checks++;
      if ({busy, grant_vld, ddr_start, timeout, grant_id, req_endp} !== '0 ||
          {ddr_wxr, ddr_area, ddr_addr, ddr_size} !== '0) begin
         n_fail++;
         $display("FAIL rst_async: ctrl=%b cmd=%h want 0", {busy, grant_vld, ddr_start, timeout, grant_id, req_endp},
                  {ddr_wxr, ddr_area, ddr_addr, ddr_size});
      end
      repeat (2) tick();
      rst_n = 1'b1;
      m_reset();
      acc_start = 1'b0;
      acc_endp  = '0;
      for (int i = 0; i < 10; i++) begin
         tick();
         acc_start |= ddr_start;
         acc_endp  |= req_endp;
      end
      n_checks++;
      if (acc_start !== 1'b0 || acc_endp !== '0) begin
         n_fail++;
         $display("FAIL rst_drop: start=%b endp=%b want 0/0000", acc_start, acc_endp);
      end
   endtask

   task automatic test_random();
      int n, g, j, guard;
      bit ok, exp_ovf;
      logic [N-1:0] mask;
      for (int r = 0; r < 8; r++) begin
         mask = N'($urandom_range(15, 1));
         for (int i = 0; i < N; i++) if (mask[i]) begin
            set_cmd(i, rand_cmd());
            void'(m_request(i, {req_wxr[i], req_area[i*4 +: 4], req_addr[i*27 +: 27], req_size[i*32 +: 32]}));
         end
         pulse(mask);
         guard = 0;
         while (m_pick() != -1 && guard < 16) begin
            guard++;
            wait_start(8, n, ok);
            g = m_pick();
            n_checks++;
            if (!ok || grant_id !== 3'(g) || {ddr_wxr, ddr_area, ddr_addr, ddr_size} !== m_cmd[g]) begin
               n_fail++;
               $display("FAIL rand_grant[%0d]: seen=%0b id=%0d cmd=%h want id=%0d cmd=%h", r, ok, grant_id,
                        {ddr_wxr, ddr_area, ddr_addr, ddr_size}, g, m_cmd[g]);
            end
            m_grant(g);
            tick();
            if ($urandom_range(1, 0) == 1) begin
               ddr_cmd_t c;
               j = $urandom_range(N-1, 0);
               c = rand_cmd();
               set_cmd(j, c);
               exp_ovf = m_request(j, c);
               pulse(onehot(j));
               n_checks++;
               if (req_ovf !== (exp_ovf ? onehot(j) : '0)) begin
                  n_fail++;
                  $display("FAIL rand_ovf[%0d]: got %b want %b", r, req_ovf, exp_ovf ? onehot(j) : '0);
               end
            end else begin
               tick();
            end
            drive_endp($urandom_range(8, 0));
            n_checks++;
            if (req_endp !== onehot(g)) begin
               n_fail++;
               $display("FAIL rand_endp[%0d]: got %b want %b", r, req_endp, onehot(g));
            end
         end
         repeat (2) tick();
      end
   endtask

   initial begin
      m_reset();
      test_reset();
      test_single();
      test_fairness();
      test_overflow();
      test_self_rerequest();
      test_timeout();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, %0d failures so far", n_fail);
      $fatal(1, "simulation time limit");
   end

endmodule
